ddr2_refresh_scheduler: RTL and testbench

Generates AUTO REFRESH requests for the DDR2 controller at a programmable tREFI cadence. Tracks postponed refreshes as credits, escalates urgency as debt grows, and enforces the tRFC blackout after each issued refresh. Sits between the controller's ready/low-power state and the command arbiter. The arbiter grants the request by issuing the REFRESH command on the pads. Its output is what the pad-level refresh interval checker validates.

---
 rtl/ddr2_refresh_scheduler.sv | 109 ++++++++++
 tb/tb_ddr2_refresh_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_refresh_scheduler.sv
// rtl/ddr2_refresh_scheduler.sv - DDR2 auto-refresh request scheduler with postponement credits and tRFC blackout
module ddr2_refresh_scheduler #(
  parameter int TREFI_CLK     = 7800,
  parameter int TRFC_CLK      = 51,
  parameter int MAX_POSTPONE  = 8,
  parameter int URGENT_THRESH = 4
) (
  input  logic       clk,
  input  logic       resetbar,
  input  logic       ready_i,
  input  logic       sr_active_i,
  input  logic       ref_ack_i,
  output logic       ref_req_o,
  output logic       ref_urgent_o,
  output logic       ref_busy_o,
  output logic [3:0] pending_o,
  output logic       overflow_err_o
);

  localparam int CNT_W = (TREFI_CLK > 1) ? $clog2(TREFI_CLK) : 1;
  localparam int RFC_W = $clog2(TRFC_CLK + 1);
  localparam logic [CNT_W-1:0] INTERVAL_LAST = CNT_W'(TREFI_CLK - 1);
  localparam logic [RFC_W-1:0] RFC_LOAD      = RFC_W'(TRFC_CLK - 1);
  localparam logic [3:0]       PEND_MAX      = 4'(MAX_POSTPONE);
  localparam logic [3:0]       PEND_URGENT   = 4'(URGENT_THRESH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_TRFC = 1'b1;

  logic [CNT_W-1:0] interval_q, interval_d;
  logic [3:0]       pending_q, pending_d;
  logic [0:0]       state_q, state_d;
  logic [RFC_W-1:0] rfc_q, rfc_d;
  logic             overflow_q, overflow_d;

  logic counting;
  logic tick;
  logic ack_accepted;

  assign ref_req_o      = (state_q == ST_IDLE) && (pending_q != 4'd0) && ready_i;
  assign ref_busy_o     = (state_q == ST_TRFC);
  assign ref_urgent_o   = (pending_q >= PEND_URGENT);
  assign pending_o      = pending_q;
  assign overflow_err_o = overflow_q;

  always_comb begin
    counting     = ready_i && !sr_active_i;
    tick         = counting && (interval_q == INTERVAL_LAST);
    ack_accepted = ref_req_o && ref_ack_i;

    interval_d = interval_q;
    if (!ready_i) begin
      interval_d = '0;
    end else if (counting) begin
      interval_d = tick ? '0 : interval_q + 1'b1;
    end

    // A tick against a full credit pool is lost and latched as an error.
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (!ready_i) begin
      pending_d = 4'd0;
    end else if (tick && !ack_accepted) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 4'd1;
      end
    end else if (ack_accepted && !tick) begin
      pending_d = pending_q - 4'd1;
    end

    // The blackout ignores ready_i so an issued refresh always completes.
    state_d = state_q;
    rfc_d   = rfc_q;
    case (state_q)
      ST_IDLE: begin
        if (ack_accepted) begin
          state_d = ST_TRFC;
          rfc_d   = RFC_LOAD;
        end
      end
      default: begin
        if (rfc_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          rfc_d = rfc_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetbar) begin
    if (!resetbar) begin
      interval_q <= '0;
      pending_q  <= 4'd0;
      state_q    <= ST_IDLE;
      rfc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      interval_q <= interval_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      rfc_q      <= rfc_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_ddr2_refresh_scheduler.sv
// tb/tb_ddr2_refresh_scheduler.sv - scoreboard bench for ddr2_refresh_scheduler against a credit-arithmetic model
module tb_ddr2_refresh_scheduler;

  localparam int TREFI = 100;
  localparam int TRFC  = 10;
  localparam int MAXP  = 8;
  localparam int URG   = 4;

  localparam int ACK_NEVER  = 0;
  localparam int ACK_ALWAYS = 1;
  localparam int ACK_RANDOM = 2;

  typedef struct packed {
    logic       req;
    logic       urgent;
    logic       busy;
    logic [3:0] pending;
    logic       overflow;
  } obs_t;

  logic       clk = 1'b0;
  logic       resetbar = 1'b1;
  logic       ready_i = 1'b0;
  logic       sr_active_i = 1'b0;
  logic       ref_ack_i = 1'b0;
  logic       ref_req_o;
  logic       ref_urgent_o;
  logic       ref_busy_o;
  logic [3:0] pending_o;
  logic       overflow_err_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  obs_t exp_q[$];
  obs_t mon_exp;
  obs_t mon_got;

  // Reference model: counting-cycle total, credit count, remaining blackout cycles.
  int m_count = 0;
  int m_pend  = 0;
  int m_busy  = 0;
  bit m_ovf   = 1'b0;

  ddr2_refresh_scheduler #(
    .TREFI_CLK(TREFI),
    .TRFC_CLK(TRFC),
    .MAX_POSTPONE(MAXP),
    .URGENT_THRESH(URG)
  ) dut (
    .clk(clk),
    .resetbar(resetbar),
    .ready_i(ready_i),
    .sr_active_i(sr_active_i),
    .ref_ack_i(ref_ack_i),
    .ref_req_o(ref_req_o),
    .ref_urgent_o(ref_urgent_o),
    .ref_busy_o(ref_busy_o),
    .pending_o(pending_o),
    .overflow_err_o(overflow_err_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    obs_t o;
    o.req      = ref_req_o;
    o.urgent   = ref_urgent_o;
    o.busy     = ref_busy_o;
    o.pending  = pending_o;
    o.overflow = overflow_err_o;
    return o;
  endfunction

  function automatic obs_t model_obs(bit r);
    obs_t o;
    o.req      = (m_busy == 0) && (m_pend > 0) && r;
    o.urgent   = (m_pend >= URG);
    o.busy     = (m_busy > 0);
    o.pending  = 4'(m_pend);
    o.overflow = m_ovf;
    return o;
  endfunction

  task automatic model_step(bit r, bit s, bit a);
    bit req, acc, tick;
    req  = (m_busy == 0) && (m_pend > 0) && r;
    acc  = req && a;
    tick = r && !s && (((m_count + 1) % TREFI) == 0);
    if (!r) begin
      m_count = 0;
      m_pend  = 0;
    end else begin
      if (!s) m_count++;
      m_pend = m_pend + int'(tick) - int'(acc);
      if (m_pend > MAXP) begin
        m_pend = MAXP;
        m_ovf  = 1'b1;
      end
    end
    if (acc) m_busy = TRFC;
    else if (m_busy > 0) m_busy--;
  endtask

  task automatic cycle(bit r, bit s, int mode);
    bit a;
    a = (mode == ACK_ALWAYS) ? 1'b1 :
        (mode == ACK_RANDOM) ? ($urandom_range(0, 3) == 0) : 1'b0;
    ready_i     = r;
    sr_active_i = s;
    ref_ack_i   = a;
    exp_q.push_back(model_obs(r));
    @(posedge clk);
    #2;
    model_step(r, s, a);
  endtask

  task automatic run(int n, bit r, bit s, int mode);
    for (int i = 0; i < n; i++) cycle(r, s, mode);
  endtask

  task automatic do_reset();
    obs_t got;
    resetbar    = 1'b0;
    ready_i     = 1'b0;
    sr_active_i = 1'b0;
    ref_ack_i   = 1'b0;
    #1;
    got = dut_obs();
    chk_cnt++;
    if (got !== '0) $display("FAIL async_reset got=%b required=%b", got, 8'b0);
    else pass_cnt++;
    m_count = 0;
    m_pend  = 0;
    m_busy  = 0;
    m_ovf   = 1'b0;
    #1;
    cycle(1'b0, 1'b0, ACK_NEVER);
    cycle(1'b0, 1'b0, ACK_NEVER);
    resetbar = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = dut_obs();
        chk_cnt++;
        if (mon_got !== mon_exp)
          $display("FAIL outputs t=%0t got req=%b urg=%b busy=%b pend=%0d ovf=%b required req=%b urg=%b busy=%b pend=%0d ovf=%b",
                   $time, mon_got.req, mon_got.urgent, mon_got.busy, mon_got.pending, mon_got.overflow,
                   mon_exp.req, mon_exp.urgent, mon_exp.busy, mon_exp.pending, mon_exp.overflow);
        else pass_cnt++;
      end
    end
  end

  initial begin
    @(posedge clk);
    #2;
    do_reset();

    // First tick, then acks on every request across several intervals.
    run(100, 1'b1, 1'b0, ACK_NEVER);
    run(250, 1'b1, 1'b0, ACK_ALWAYS);

    // Build four credits, drain them, then push past saturation.
    do_reset();
    run(400, 1'b1, 1'b0, ACK_NEVER);
    run(60, 1'b1, 1'b0, ACK_ALWAYS);
    run(1000, 1'b1, 1'b0, ACK_NEVER);
    run(5, 1'b0, 1'b0, ACK_NEVER);
    run(50, 1'b1, 1'b0, ACK_NEVER);
    do_reset();
    run(20, 1'b1, 1'b0, ACK_NEVER);

    // Ack landing on the same edge as the third tick, pending two.
    do_reset();
    run(299, 1'b1, 1'b0, ACK_NEVER);
    run(1, 1'b1, 1'b0, ACK_ALWAYS);
    run(30, 1'b1, 1'b0, ACK_NEVER);

    // Self-refresh pause starting at count 50.
    do_reset();
    run(50, 1'b1, 1'b0, ACK_NEVER);
    run(250, 1'b1, 1'b1, ACK_NEVER);
    run(60, 1'b1, 1'b0, ACK_NEVER);

    // Random segments of ready, pause and ack behaviour.
    do_reset();
    for (int seg = 0; seg < 25; seg++) begin
      run($urandom_range(20, 200), ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
          $urandom_range(0, 2));
    end

    // Reset asserted in the middle of a blackout window.
    do_reset();
    run(100, 1'b1, 1'b0, ACK_NEVER);
    run(4, 1'b1, 1'b0, ACK_ALWAYS);
    do_reset();
    run(10, 1'b1, 1'b0, ACK_NEVER);

    @(negedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
